ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receiver directly upstream of `scancode_decoder`. It oversamples the keyboard's `ps2_clk`/`ps2_data` lines in the system clock domain and deserializes 11-bit device-to-host frames. It folds the Set 2 prefixes `E0` (extended) and `F0` (break) into flags, and emits each completed scan code as a single-cycle pulse. `scan_code` connects straight to the decoder's `scan_code` input; consumers qualify it with `scan_valid && !is_break`.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_sync_edge.sv | 34 +++
 rtl/ps2_keyboard_rx.sv | 121 ++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: Set 2 prefix bytes,
// FSM state encoding and the frame integrity check.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Odd parity over data+parity, and the stop bit must be high.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchronizer for the PS/2 clock and data pads plus a
// falling-edge detector on the synchronized clock.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   clk_prev;

    // Reset loads ones so an idle bus never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign data_sync = data_sr[SYNC_STAGES-1];
    assign clk_fall  = clk_prev & ~clk_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: deserializes 11-bit frames, folds
// E0/F0 prefixes into flags and emits one pulse per completed scan code.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          data_sync;
    logic          clk_fall;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          pend_ext;
    logic          pend_brk;
    logic          to_hit;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(data_sync),
        .clk_fall (clk_fall)
    );

    // An edge in the same cycle as expiry wins, so the frame keeps going.
    assign to_hit = (state != ST_IDLE) && !clk_fall && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            pend_ext    <= 1'b0;
            pend_brk    <= 1'b0;
            scan_code   <= 8'h00;
            scan_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;

            if (clk_fall || state == ST_IDLE)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);

            if (to_hit) begin
                state       <= ST_IDLE;
                to_cnt      <= '0;
                frame_error <= 1'b1;
                pend_ext    <= 1'b0;
                pend_brk    <= 1'b0;
            end else if (clk_fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg <= {data_sync, shreg[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: begin
                        par_bit <= data_sync;
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (frame_ok(shreg, par_bit, data_sync)) begin
                            if (shreg == PS2_PREFIX_EXT) begin
                                pend_ext <= 1'b1;
                            end else if (shreg == PS2_PREFIX_BREAK) begin
                                pend_brk <= 1'b1;
                            end else begin
                                scan_code   <= shreg;
                                is_break    <= pend_brk;
                                is_extended <= pend_ext;
                                scan_valid  <= 1'b1;
                                pend_ext    <= 1'b0;
                                pend_brk    <= 1'b0;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            pend_ext    <= 1'b0;
                            pend_brk    <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames bit by bit and
// compares the outputs and pulse counts against hand-computed values.
module tb_ps2_keyboard_rx;

    localparam int TO = 200;
    localparam int H  = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_error;

    int n_checks = 0;
    int n_pass   = 0;
    int nv = 0, ne = 0, nboth = 0;
    int dv, de;

    ps2_keyboard_rx #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .is_break   (is_break),
        .is_extended(is_extended),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scan_valid) nv <= nv + 1;
        if (frame_error) ne <= ne + 1;
        if (scan_valid && frame_error) nboth <= nboth + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Sends the first nbits of an 11-bit frame, LSB (start bit) first.
    task automatic send(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_clk(H);
            ps2_clk = 1'b0;
            wait_clk(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Full frame; dv/de receive the scan_valid / frame_error pulse counts it caused.
    task automatic frame(input logic [7:0] b, input logic bad_par, input logic stop);
        int v0, e0;
        v0 = nv;
        e0 = ne;
        send(b, bad_par, stop, 11);
        wait_clk(10);
        dv = nv - v0;
        de = ne - e0;
    endtask

    initial begin
        int v0, e0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        chk("rst_code", {24'd0, scan_code}, 32'h00);
        chk("rst_valid", {31'd0, scan_valid}, 32'd0);
        chk("rst_break", {31'd0, is_break}, 32'd0);
        chk("rst_ext", {31'd0, is_extended}, 32'd0);
        chk("rst_ferr", {31'd0, frame_error}, 32'd0);
        wait_clk(20);

        frame(8'h1C, 1'b0, 1'b1);
        chk("1c_pulses", dv, 1);
        chk("1c_errs", de, 0);
        chk("1c_code", {24'd0, scan_code}, 32'h1C);
        chk("1c_break", {31'd0, is_break}, 32'd0);
        chk("1c_ext", {31'd0, is_extended}, 32'd0);

        frame(8'hF0, 1'b0, 1'b1);
        chk("f0_pulses", dv, 0);
        frame(8'h1C, 1'b0, 1'b1);
        chk("brk_pulses", dv, 1);
        chk("brk_code", {24'd0, scan_code}, 32'h1C);
        chk("brk_break", {31'd0, is_break}, 32'd1);
        frame(8'h1C, 1'b0, 1'b1);
        chk("make_break", {31'd0, is_break}, 32'd0);

        frame(8'hE0, 1'b0, 1'b1);
        chk("e0_pulses", dv, 0);
        frame(8'h5A, 1'b0, 1'b1);
        chk("ext_pulses", dv, 1);
        chk("ext_code", {24'd0, scan_code}, 32'h5A);
        chk("ext_ext", {31'd0, is_extended}, 32'd1);
        chk("ext_break", {31'd0, is_break}, 32'd0);

        frame(8'hE0, 1'b0, 1'b1);
        frame(8'hF0, 1'b0, 1'b1);
        frame(8'h5A, 1'b0, 1'b1);
        chk("eb_pulses", dv, 1);
        chk("eb_ext", {31'd0, is_extended}, 32'd1);
        chk("eb_break", {31'd0, is_break}, 32'd1);

        // 0x45 has three ones, so its correct odd parity bit is 0; drive 1 instead.
        frame(8'hF0, 1'b0, 1'b1);
        frame(8'h45, 1'b1, 1'b1);
        chk("par_errs", de, 1);
        chk("par_pulses", dv, 0);
        chk("par_code_held", {24'd0, scan_code}, 32'h5A);
        frame(8'h1C, 1'b0, 1'b1);
        chk("par_forget_brk", {31'd0, is_break}, 32'd0);
        chk("par_after_code", {24'd0, scan_code}, 32'h1C);

        frame(8'h33, 1'b0, 1'b0);
        chk("stop_errs", de, 1);
        chk("stop_pulses", dv, 0);

        v0 = nv;
        e0 = ne;
        send(8'h00, 1'b0, 1'b1, 5);
        wait_clk(TO + 60);
        chk("to_errs", ne - e0, 1);
        chk("to_pulses", nv - v0, 0);
        frame(8'h16, 1'b0, 1'b1);
        chk("to_next_pulses", dv, 1);
        chk("to_next_errs", de, 0);
        chk("to_next_code", {24'd0, scan_code}, 32'h16);

        frame(8'hE0, 1'b0, 1'b1);
        v0 = nv;
        e0 = ne;
        send(8'h26, 1'b0, 1'b1, 5);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(TO + 60);
        chk("mid_rst_code", {24'd0, scan_code}, 32'h00);
        chk("mid_rst_flags", {30'd0, is_break, is_extended}, 32'd0);
        chk("mid_rst_pulses", nv - v0, 0);
        chk("mid_rst_errs", ne - e0, 0);
        frame(8'h26, 1'b0, 1'b1);
        chk("post_rst_pulses", dv, 1);
        chk("post_rst_code", {24'd0, scan_code}, 32'h26);
        chk("post_rst_ext", {31'd0, is_extended}, 32'd0);
        chk("post_rst_break", {31'd0, is_break}, 32'd0);

        chk("no_overlap", nboth, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
